i2c_apb_master: RTL and testbench
=================================

# i2c_apb_master

APB initiator that drives the I2C controller's register slave from a simple valid/ready command stream, for use by on-chip sequencers and the verification harness. Each accepted command becomes exactly one APB read or write transfer (setup phase, then access phase); the block returns read data or completion status on a response channel. Addresses outside the controller's register map are rejected locally, without an APB transfer.

## Interface
Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum number of access-phase cycles spent waiting for pready. Used only when the macro is defined. Range 2..255.

Ports:
- pclk  in  1  clock.
- prst  in  1  reset. Synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted on the cycle where cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  address rejected, or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready. Ignored when the macro is not defined.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- All outputs are registered.
- Reset (prst = 1 at a pclk edge) forces the following, regardless of state. An in-flight transfer is abandoned and no response is produced.
  - state = IDLE
  - psel, penable, pwrite, rsp_valid, rsp_err = 0
  - paddr, pwdata, rsp_rdata = 0
  - cmd_ready = 1 on the first cycle after reset.
- Valid address set: 0x1C, 0x20, 0x24, 0x28, 0x2C, 0x30, 0x34, 0x38, 0x3C, 0x40.
  - Address 0x34 is read-only; 0x38 is read-only.
  - A write to 0x34 or 0x38 is invalid.
- IDLE:
  - cmd_ready = 1.
  - On accept with a valid address:
    - latch paddr, pwrite, pwdata (pwdata is latched as 0 for reads).
    - go to SETUP.
  - On accept with an invalid address:
    - go to RESP with rsp_err = 1 and rsp_rdata = 0.
    - psel never rises.
- SETUP: psel = 1, penable = 0. Go to ACCESS unconditionally.
- ACCESS: psel = 1, penable = 1.
  - The transfer completes at the edge where pready = 1, or on the first access cycle when the macro is not defined.
  - On completion:
    - capture prdata into rsp_rdata for reads; capture 0 for writes.
    - drop psel and penable.
    - go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid.
  - cmd_ready = 0 in every state except IDLE, so only one transaction is outstanding at a time.
- paddr, pwrite and pwdata are held stable from SETUP through the last ACCESS cycle. They keep their values afterwards; only psel and penable return to 0.

## Timing
- Command accepted at edge N:
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2.
  - rsp_valid in cycle N+3, in the zero-wait case.
- Invalid address accepted at edge N: rsp_valid in cycle N+1.
- Each pready wait cycle adds one cycle of latency.
- Back-to-back throughput: if rsp_ready is held at 1, rsp_valid lasts one cycle and IDLE accepts the next command on the following cycle. Minimum period is 4 cycles per transfer.
- rsp_ready is ignored outside RESP.
- cmd_* inputs are ignored while cmd_ready = 0.

## Configuration
- Macro: I2C_APB_MST_PREADY_EN.
- Defined:
  - ACCESS waits on pready.
  - An 8-bit wait counter is cleared on entry to ACCESS and increments every ACCESS cycle with pready = 0.
  - Timeout fires when the counter reaches TIMEOUT - 1 with pready still 0:
    - psel and penable drop.
    - go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - If pready = 1 on the same cycle the counter reaches the limit, it is a normal completion with rsp_err = 0.
- Not defined:
  - pready is unused.
  - ACCESS always lasts exactly one cycle.
  - No counter and no timeout error exist.

## Structure
- Shared package i2c_apb_pkg holds:
  - the FSM state enum;
  - the register address constants (CON 0x1C, SE 0x20, ADD 0x24, COM 0x28, DT 0x2C, IE 0x30, ST 0x34, IF 0x38, CD 0x3C, TADD 0x40);
  - the address-valid function, including the read-only check.
- No sub-module: the FSM, address check and wait counter are a single module.

## Test plan
- Write 0x0000_0005 to 0x1C, rsp_ready = 1:
  - psel = 1 at N+1; psel = penable = 1 at N+2; pwdata = 5 throughout.
  - rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read 0x2C with prdata = 0x0000_00A5:
  - rsp_rdata = 0xA5, rsp_err = 0.
  - The access phase lasts exactly one cycle (pready = 1).
- Read 0x44, then write 0x34:
  - each response arrives at N+1 with rsp_err = 1.
  - psel stays 0 throughout.
- With I2C_APB_MST_PREADY_EN defined and TIMEOUT = 16:
  - pready held low for 3 cycles: completes normally at N+6.
  - pready held low permanently: rsp_err = 1 after 16 access cycles.
- Hold rsp_ready = 0 for 5 cycles after rsp_valid, with cmd_valid = 1:
  - cmd_ready stays 0 and rsp_rdata stays stable.
  - The next command is accepted one cycle after the rsp_ready handshake.
- Assert prst during ACCESS:
  - next cycle: psel = penable = rsp_valid = 0, cmd_ready = 1.
  - no response is ever produced for the aborted command.

Source files
------------

// File: rtl/i2c_apb_pkg.sv
// i2c_apb_pkg
//   Shared definitions for the I2C controller APB initiator:
//   - state_t     : initiator FSM states
//   - REG_*       : register offsets of the I2C controller slave
//   - addr_valid(): register-map membership check, rejecting writes to
//                   the read-only registers ST and IF
//   Addresses are compared as 32-bit values; callers with narrower
//   address buses zero-extend.
package i2c_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [31:0] REG_CON  = 32'h1C;
  localparam logic [31:0] REG_SE   = 32'h20;
  localparam logic [31:0] REG_ADD  = 32'h24;
  localparam logic [31:0] REG_COM  = 32'h28;
  localparam logic [31:0] REG_DT   = 32'h2C;
  localparam logic [31:0] REG_IE   = 32'h30;
  localparam logic [31:0] REG_ST   = 32'h34;
  localparam logic [31:0] REG_IF   = 32'h38;
  localparam logic [31:0] REG_CD   = 32'h3C;
  localparam logic [31:0] REG_TADD = 32'h40;

  function automatic logic addr_valid(input logic [31:0] addr, input logic wr);
    logic ok;
    ok = 1'b0;
    case (addr)
      REG_CON, REG_SE, REG_ADD, REG_COM, REG_DT,
      REG_IE, REG_CD, REG_TADD: ok = 1'b1;
      REG_ST, REG_IF:           ok = !wr;
      default:                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/i2c_apb_master.sv
// i2c_apb_master
//   Turns a valid/ready command stream into single APB read/write
//   transfers towards the I2C controller register slave and returns the
//   outcome on a valid/ready response channel. Addresses outside the
//   register map (or writes to read-only registers) are answered locally
//   with rsp_err and never reach the bus. One transaction in flight.
//
//   Ports:
//     pclk, prst            clock, synchronous active-high reset
//     cmd_valid/cmd_ready   command handshake
//     cmd_write/addr/wdata  command payload
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata, rsp_err    read data (0 for writes/errors), error flag
//     psel..pwdata          APB request outputs
//     prdata, pready        APB completion inputs
//
//   Optional feature: define I2C_APB_MST_PREADY_EN to make the access
//   phase wait on pready, with a timeout after TIMEOUT access cycles.
//   Without it pready is unused and every access lasts one cycle.
import i2c_apb_pkg::*;

module i2c_apb_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  state_t state;
  logic   addr_ok;

  assign addr_ok = addr_valid(32'(cmd_addr), cmd_write);

`ifdef I2C_APB_MST_PREADY_EN
  logic [7:0] wait_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = pready | (TIMEOUT > 0);
`endif

  always_ff @(posedge pclk) begin
    if (prst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef I2C_APB_MST_PREADY_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (addr_ok) begin
              paddr  <= cmd_addr;
              pwrite <= cmd_write;
              pwdata <= cmd_write ? cmd_wdata : '0;
              psel   <= 1'b1;
              state  <= SETUP;
            end else begin
              // Rejected locally: answer next cycle, bus untouched.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end

        SETUP: begin
          penable <= 1'b1;
`ifdef I2C_APB_MST_PREADY_EN
          wait_cnt <= '0;
`endif
          state   <= ACCESS;
        end

        ACCESS: begin
`ifdef I2C_APB_MST_PREADY_EN
          // pready wins over the timeout on the limit cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
            state     <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`else
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= pwrite ? '0 : prdata;
          state     <= RESP;
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          psel      <= 1'b0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_apb_master.sv
module tb_i2c_apb_master;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 pclk = ~pclk;

  i2c_apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic [7:0]  waits;      // access cycles with pready low (255 = forever)
    logic        exp_err;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;    // cycles from accept edge to rsp_valid
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Issues one command from IDLE and follows it until rsp_valid;
  // returns during the first response cycle.
  task automatic do_cmd(input vec_t v);
    int unsigned c;
    bit seen;
    logic [31:0] exp_pwdata;
    exp_pwdata = v.write ? v.wdata : 32'h0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    prdata = v.prdata;
    step();
    c = 1;
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'hFFFF_FFFF; cmd_write = ~v.write;
    chk("cmd_ready_busy", cmd_ready, 0);
    seen = 1'b0;
    while (c <= 40 && !seen) begin
      pready = (c >= 2 + int'(v.waits)) && (v.waits != 8'd255);
      if (c == 1) begin
        chk("psel_setup", psel, (v.exp_lat != 1) ? 1 : 0);
        chk("penable_setup", penable, 0);
      end
      if (c == 2 && v.exp_lat > 2) begin
        chk("psel_access", psel, 1);
        chk("penable_access", penable, 1);
        chk("paddr", paddr, v.addr);
        chk("pwrite", pwrite, v.write);
        chk("pwdata", pwdata, exp_pwdata);
      end
      if (rsp_valid) begin
        seen = 1'b1;
        chk("rsp_latency", c, v.exp_lat);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("psel_resp", psel, 0);
        chk("penable_resp", penable, 0);
      end else begin
        step();
        c++;
      end
    end
    if (!seen) chk("rsp_wait_expired", 0, 1);
    pready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t h;
    int unsigned cnt;
    logic [31:0] held;

    // write/addr/wdata/prdata/waits/err/rdata/lat
    vecs[0]  = '{1'b1, 8'h1C, 32'h0000_0005, 32'h0000_DEAD, 8'd0, 1'b0, 32'h0, 3};
    vecs[1]  = '{1'b0, 8'h2C, 32'h1111_1111, 32'h0000_00A5, 8'd0, 1'b0, 32'hA5, 3};
    vecs[2]  = '{1'b0, 8'h44, 32'h0,         32'h1234_5678, 8'd0, 1'b1, 32'h0, 1};
    vecs[3]  = '{1'b1, 8'h34, 32'hABCD_0000, 32'h1234_5678, 8'd0, 1'b1, 32'h0, 1};
    vecs[4]  = '{1'b0, 8'h34, 32'h0,         32'h1234_5678, 8'd0, 1'b0, 32'h1234_5678, 3};
    vecs[5]  = '{1'b1, 8'h38, 32'h0000_00FF, 32'h0,         8'd0, 1'b1, 32'h0, 1};
    vecs[6]  = '{1'b1, 8'h40, 32'hCAFE_F00D, 32'h5555_AAAA, 8'd0, 1'b0, 32'h0, 3};
    vecs[7]  = '{1'b0, 8'h1B, 32'h0,         32'h0000_0001, 8'd0, 1'b1, 32'h0, 1};
    vecs[8]  = '{1'b0, 8'h40, 32'h0,         32'h8000_0001, 8'd0, 1'b0, 32'h8000_0001, 3};
    vecs[9]  = '{1'b1, 8'h3C, 32'h0000_0042, 32'hFFFF_FFFF, 8'd0, 1'b0, 32'h0, 3};
    vecs[10] = '{1'b0, 8'h1E, 32'h0,         32'h0000_0007, 8'd0, 1'b1, 32'h0, 1};

    prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b1;
    step(); step(); step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    prst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) begin
      do_cmd(vecs[i]);
      step();
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("cmd_ready_after", cmd_ready, 1);
    end

`ifdef I2C_APB_MST_PREADY_EN
    h = '{1'b0, 8'h30, 32'h0, 32'h0000_0077, 8'd3, 1'b0, 32'h77, 6};
    do_cmd(h); step();
    h = '{1'b0, 8'h2C, 32'h0, 32'h0000_0099, 8'd255, 1'b1, 32'h0, 18};
    do_cmd(h); step();
    h = '{1'b0, 8'h28, 32'h0, 32'h0000_0031, 8'd15, 1'b0, 32'h31, 18};
    do_cmd(h); step();
    h = '{1'b1, 8'h24, 32'h0000_0010, 32'h0000_0031, 8'd255, 1'b1, 32'h0, 18};
    do_cmd(h); step();
`endif

    // Response back-pressure with a competing command offered.
    rsp_ready = 1'b0;
    h = '{1'b0, 8'h3C, 32'h0, 32'h5A5A_1234, 8'd0, 1'b0, 32'h5A5A_1234, 3};
    do_cmd(h);
    held = rsp_rdata;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h24; prdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, held);
    end
    chk("hold_psel", psel, 0);
    rsp_ready = 1'b1;
    step();
    chk("handshake_rsp_valid", rsp_valid, 0);
    chk("handshake_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("next_accept_psel", psel, 1);
    chk("next_accept_paddr", paddr, 8'h24);
    cnt = 0;
    while (!rsp_valid && cnt < 30) begin step(); cnt++; end
    chk("next_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
    step();

    // Reset during the access phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h0000_00C3;
    step();
    cmd_valid = 1'b0;
    step();
    chk("abort_in_access", penable, 1);
    prst = 1'b1;
    step();
    prst = 1'b0;
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) cnt++;
    end
    chk("abort_no_response", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
